// File: rtl/psum_merge_arbiter.sv
// Round-robin merge of per-core partial-sum vectors into one lane-wise signed sum per round.
// Optional macro PSUM_SAT_EN: saturating lane adds with sat_flag; otherwise wrapping adds.
`ifndef NUM_CORE_V
`define NUM_CORE_V 4
`endif
`ifndef NUM_HN_ONECORE
`define NUM_HN_ONECORE 10
`endif
`ifndef BW_PS
`define BW_PS 16
`endif

module psum_merge_arbiter #(
    parameter int NUM_REQ = `NUM_CORE_V,
    parameter int LANES   = `NUM_HN_ONECORE,
    parameter int BW_PS   = `BW_PS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*LANES*BW_PS-1:0]   psum_in,
    output logic [NUM_REQ-1:0]               ack,
    output logic                             sum_valid,
    output logic [LANES*BW_PS-1:0]           sum_out,
    output logic                             sat_flag
);
    localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SLICE = LANES * BW_PS;

    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

    state_t             state_q, state_d;
    logic [SLICE-1:0]   acc_q, acc_d, sum_out_q, sum_out_d;
    logic [NUM_REQ-1:0] served_q, served_d, ack_q, ack_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               sat_acc_q, sat_acc_d, sat_flag_q, sat_flag_d;
    logic               sum_valid_q, sum_valid_d;

    logic [NUM_REQ-1:0] pending, gnt_oh;
    logic [PW-1:0]      gnt_idx;
    logic               gnt_vld;
    logic [SLICE-1:0]   sel_slice, add_res;
    logic               add_sat;
    logic [BW_PS-1:0]   lane_a, lane_b;
`ifdef PSUM_SAT_EN
    logic [BW_PS:0]     lane_s;
`endif

    // Search upward from the slot after the last grant, wrapping.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        pending = req & ~served_q;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(rr_ptr_q) + i) % 32'(NUM_REQ);
            if (!gnt_vld && pending[PW'(idx)]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
        if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
    end

    always_comb begin
        sel_slice = '0;
        for (int unsigned c = 0; c < NUM_REQ; c++) begin
            if (gnt_oh[c]) sel_slice = psum_in[c*SLICE +: SLICE];
        end
    end

    always_comb begin
        add_res = '0;
        add_sat = 1'b0;
        lane_a  = '0;
        lane_b  = '0;
`ifdef PSUM_SAT_EN
        lane_s  = '0;
`endif
        for (int unsigned d = 0; d < LANES; d++) begin
            lane_a = acc_q[d*BW_PS +: BW_PS];
            lane_b = sel_slice[d*BW_PS +: BW_PS];
`ifdef PSUM_SAT_EN
            lane_s = {lane_a[BW_PS-1], lane_a} + {lane_b[BW_PS-1], lane_b};
            if (lane_s[BW_PS] != lane_s[BW_PS-1]) begin
                add_sat = 1'b1;
                add_res[d*BW_PS +: BW_PS] = lane_s[BW_PS] ? {1'b1, {(BW_PS-1){1'b0}}}
                                                          : {1'b0, {(BW_PS-1){1'b1}}};
            end else begin
                add_res[d*BW_PS +: BW_PS] = lane_s[BW_PS-1:0];
            end
`else
            add_res[d*BW_PS +: BW_PS] = lane_a + lane_b;
`endif
        end
    end

    // Outputs are registered: ack follows its grant edge, sum_valid follows the EMIT cycle.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        served_d    = served_q;
        rr_ptr_d    = rr_ptr_q;
        ack_d       = '0;
        sum_valid_d = 1'b0;
        sum_out_d   = sum_out_q;
        sat_acc_d   = sat_acc_q;
        sat_flag_d  = sat_flag_q;
        if (en) begin
            case (state_q)
                IDLE, COLLECT: begin
                    if (gnt_vld) begin
                        acc_d     = add_res;
                        served_d  = served_q | gnt_oh;
                        rr_ptr_d  = gnt_idx;
                        ack_d     = gnt_oh;
                        sat_acc_d = sat_acc_q | add_sat;
                        state_d   = (served_d == '1) ? EMIT : COLLECT;
                    end
                end
                EMIT: begin
                    sum_valid_d = 1'b1;
                    sum_out_d   = acc_q;
                    sat_flag_d  = sat_acc_q;
                    acc_d       = '0;
                    served_d    = '0;
                    sat_acc_d   = 1'b0;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            served_q    <= '0;
            rr_ptr_q    <= PW'(NUM_REQ - 1);
            ack_q       <= '0;
            sum_valid_q <= 1'b0;
            sum_out_q   <= '0;
            sat_acc_q   <= 1'b0;
            sat_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            served_q    <= served_d;
            rr_ptr_q    <= rr_ptr_d;
            ack_q       <= ack_d;
            sum_valid_q <= sum_valid_d;
            sum_out_q   <= sum_out_d;
            sat_acc_q   <= sat_acc_d;
            sat_flag_q  <= sat_flag_d;
        end
    end

    assign ack       = ack_q;
    assign sum_valid = sum_valid_q;
    assign sum_out   = sum_out_q;
    assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_psum_merge_arbiter.sv
// Randomized self-checking bench for psum_merge_arbiter against a round-level reference model.
// Honors PSUM_SAT_EN the same way as the design.
module tb_psum_merge_arbiter;
    localparam int N    = 4;
    localparam int L    = 10;
    localparam int W    = 16;
    localparam int SMAX = (1 << (W-1)) - 1;
    localparam int SMIN = -(1 << (W-1));
`ifdef PSUM_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [N-1:0]     req;
    logic [N*L*W-1:0] psum_in;
    logic [N-1:0]     ack;
    logic             sum_valid;
    logic [L*W-1:0]   sum_out;
    logic             sat_flag;

    int             n_tests = 0;
    int             n_fail  = 0;
    int             ps[N][L];
    int             m_rr = N - 1;
    int             exp_order[$];
    logic [L*W-1:0] last_sum = '0;
    logic           last_sat = 1'b0;

    always #5 clk = ~clk;

    psum_merge_arbiter #(.NUM_REQ(N), .LANES(L), .BW_PS(W)) dut (
        .clk(clk), .rst(rst_n), .en(en), .req(req), .psum_in(psum_in),
        .ack(ack), .sum_valid(sum_valid), .sum_out(sum_out), .sat_flag(sat_flag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] lane_of(input logic [L*W-1:0] v, input int d);
        return v[d*W +: W];
    endfunction

    task automatic load_psums();
        for (int c = 0; c < N; c++)
            for (int d = 0; d < L; d++)
                psum_in[(c*L+d)*W +: W] = W'(ps[c][d]);
    endtask

    task automatic rand_psums();
        logic signed [W-1:0] t;
        for (int c = 0; c < N; c++)
            for (int d = 0; d < L; d++) begin
                t = W'($urandom);
                ps[c][d] = ($urandom_range(3) == 0) ? int'(t) : int'($urandom_range(200)) - 100;
            end
    endtask

    // Members of mask in cyclic order after the last granted core.
    task automatic add_order(input logic [N-1:0] mask);
        int p;
        int idx;
        p = (exp_order.size() > 0) ? exp_order[$] : m_rr;
        for (int i = 1; i <= N; i++) begin
            idx = (p + i) % N;
            if (mask[idx]) exp_order.push_back(idx);
        end
    endtask

    task automatic model_sum(output logic [L*W-1:0] s, output logic sat);
        int acc;
        sat = 1'b0;
        s   = '0;
        for (int d = 0; d < L; d++) begin
            acc = 0;
            foreach (exp_order[k]) begin
                acc += ps[exp_order[k]][d];
                if (SAT_ON && acc > SMAX) begin acc = SMAX; sat = 1'b1; end
                if (SAT_ON && acc < SMIN) begin acc = SMIN; sat = 1'b1; end
            end
            s[d*W +: W] = W'(acc);
        end
    endtask

    // first: cores raising req initially; the rest rise once all of first are acked.
    // hold: cycles the first batch keeps req high after being acked.
    task automatic run_round(input logic [N-1:0] first, input int off_pct, input int hold);
        logic [N-1:0]   rest, done;
        logic [L*W-1:0] exp_sum;
        logic           exp_sat;
        int             got[$];
        int             pulses, cyc, hold_cnt;
        bit             rest_up;
        rest = ~first; done = '0; pulses = 0; cyc = 0; hold_cnt = hold; rest_up = 0;
        exp_order.delete();
        add_order(first);
        add_order(rest);
        model_sum(exp_sum, exp_sat);
        load_psums();
        req = first;
        en  = 1'b1;
        while (pulses == 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (ack != '0) begin
                check("ack_onehot", 64'($onehot(ack)), 64'd1);
                check("ack_needs_en", 64'(en), 64'd1);
                for (int c = 0; c < N; c++) if (ack[c]) got.push_back(c);
                done |= ack;
                if (rest_up || hold == 0) req &= ~ack;
            end
            if (!rest_up && done == first) begin
                if (hold_cnt == 0) begin req = rest; rest_up = 1; end
                else hold_cnt--;
            end
            if (sum_valid) begin pulses++; last_sum = sum_out; last_sat = sat_flag; end
            en = ($urandom_range(99) < off_pct) ? 1'b0 : 1'b1;
        end
        req = '0;
        en  = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (sum_valid) pulses++;
            for (int c = 0; c < N; c++) if (ack[c]) got.push_back(c);
        end
        check("sum_valid_pulses", 64'(pulses), 64'd1);
        check("ack_count", 64'(got.size()), 64'(exp_order.size()));
        for (int k = 0; k < exp_order.size(); k++)
            check("ack_order", 64'((k < got.size()) ? got[k] : -1), 64'(exp_order[k]));
        for (int d = 0; d < L; d++)
            check("lane_sum", 64'(lane_of(last_sum, d)), 64'(lane_of(exp_sum, d)));
        check("sat_flag", 64'(last_sat), 64'(exp_sat));
        m_rr = exp_order[$];
    endtask

    // All four requests from IDLE with rr pointer at N-1; en dropped for gap_len
    // cycles once the core index gap_after-1 has been acked.
    task automatic timed_round(input int gap_after, input int gap_len);
        logic [N-1:0] exp_ack;
        load_psums();
        req = '1;
        en  = 1'b1;
        for (int k = 1; k <= N + 2 + gap_len; k++) begin
            @(negedge clk);
            exp_ack = '0;
            for (int c = 0; c < N; c++)
                if (k == c + 1 + ((c + 1 > gap_after) ? gap_len : 0)) exp_ack[c] = 1'b1;
            check("t_ack", 64'(ack), 64'(exp_ack));
            check("t_sum_valid", 64'(sum_valid), 64'(k == N + 1 + gap_len));
            if (sum_valid) last_sum = sum_out;
            req &= ~ack;
            en = (k >= gap_after && k < gap_after + gap_len) ? 1'b0 : 1'b1;
        end
        req = '0;
        en  = 1'b1;
    endtask

    initial begin
        int seen, cyc;
        rst_n = 1'b0; en = 1'b0; req = '0; psum_in = '0;
        #12;
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_sum_valid", 64'(sum_valid), 64'd0);
        check("rst_sum_out", 64'(sum_out), 64'd0);
        check("rst_sat", 64'(sat_flag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < N; c++) for (int d = 0; d < L; d++) ps[c][d] = 0;
        for (int c = 0; c < N; c++) ps[c][0] = c + 1;
        ps[0][5] = -3; ps[1][5] = -5; ps[2][5] = 2; ps[3][5] = 1;
        timed_round(N + 1, 0);
        check("lat_lane0", 64'(lane_of(last_sum, 0)), 64'd10);
        check("lat_lane5", 64'(lane_of(last_sum, 5)), 64'h0000_FFFB);
        check("lat_lane3", 64'(lane_of(last_sum, 3)), 64'd0);
        timed_round(2, 3);
        check("gap_lane0", 64'(lane_of(last_sum, 0)), 64'd10);
        check("gap_lane5", 64'(lane_of(last_sum, 5)), 64'h0000_FFFB);

        rand_psums();
        run_round(4'b0101, 0, 0);
        rand_psums();
        run_round(4'b0100, 0, 6);

        for (int c = 0; c < N; c++) for (int d = 0; d < L; d++) ps[c][d] = 0;
        for (int c = 0; c < N; c++) ps[c][0] = 'h7000;
        run_round(4'hF, 0, 0);
        check("sat_lane0", 64'(lane_of(last_sum, 0)), SAT_ON ? 64'h7FFF : 64'hC000);
        check("sat_flag_round", 64'(last_sat), 64'(SAT_ON));

        rand_psums();
        load_psums();
        req = '1; en = 1'b1; seen = 0; cyc = 0;
        while (seen < 2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (ack != '0) seen++;
            req &= ~ack;
        end
        check("pre_reset_acks", 64'(seen), 64'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack", 64'(ack), 64'd0);
        check("mid_rst_sum_valid", 64'(sum_valid), 64'd0);
        check("mid_rst_sum_out", 64'(sum_out), 64'd0);
        check("mid_rst_sat", 64'(sat_flag), 64'd0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m_rr  = N - 1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_quiet", 64'({ack, sum_valid}), 64'd0);
        end
        rand_psums();
        run_round(4'hF, 0, 0);

        for (int r = 0; r < 20; r++) begin
            rand_psums();
            run_round(N'($urandom_range(1, 15)), ($urandom_range(1) == 1) ? 30 : 0,
                      int'($urandom_range(3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end

endmodule
